// File: rtl/amo_ctrl.sv
// RV64A atomic memory operation sequencer: load, ALU modify, store, respond.
// Optional LR/SC reservation support is compiled in with `define AMO_LRSC_EN.
module amo_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [14:0]     op_ir,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [14:0]     alu_op_ir,
  input  logic [XLEN-1:0] alu_out,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            mem_size,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            resv_clr
);

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_AMO = 7'b0101111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_STORE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // add/xor/or/and become plain R-type ops; only min/max keep the AMO encoding
  function automatic logic [14:0] remap(input logic [4:0] f5);
    logic [14:0] m;
    m = '0;
    case (f5)
      F5_ADD:  m = {5'b0, 3'b000, OPC_OP};
      F5_XOR:  m = {5'b0, 3'b100, OPC_OP};
      F5_OR:   m = {5'b0, 3'b110, OPC_OP};
      F5_AND:  m = {5'b0, 3'b111, OPC_OP};
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: m = {f5, 3'b000, OPC_AMO};
      default: m = '0;
    endcase
    return m;
  endfunction

  logic [4:0]      w_f5;
  logic [2:0]      w_f3;
  logic            w_is_w;
  logic            w_is_d;
  logic            w_misal;
  logic            w_supp;
  logic            w_err;
  logic            w_is_lr;
  logic            w_is_sc;
  logic            w_sc_ok;
  logic            w_unused;
  logic [XLEN-1:0] w_ld;

  logic            r_is_w;
  logic            r_is_swap;
  logic            r_is_lr;
  logic            r_err;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_alu_b;
  logic [14:0]     r_alu_op;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_new;
  logic [XLEN-1:0] r_rd;

  assign w_f5    = op_ir[14:10];
  assign w_f3    = op_ir[9:7];
  assign w_is_w  = (w_f3 == 3'b010);
  assign w_is_d  = (w_f3 == 3'b011);
  assign w_misal = (w_is_d && (addr[2:0] != 3'b000)) || (w_is_w && (addr[1:0] != 2'b00));
  assign w_err   = !(w_is_w || w_is_d) || w_misal || !w_supp;
  assign w_ld    = r_is_w ? sext32(mem_rdata[31:0]) : mem_rdata;

  always_comb begin
    w_supp = 1'b0;
    case (w_f5)
      F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: w_supp = 1'b1;
`ifdef AMO_LRSC_EN
      F5_LR, F5_SC: w_supp = 1'b1;
`endif
      default: w_supp = 1'b0;
    endcase
  end

`ifdef AMO_LRSC_EN
  logic            r_resv_v;
  logic [XLEN-4:0] r_resv_a;

  assign w_is_lr  = (w_f5 == F5_LR);
  assign w_is_sc  = (w_f5 == F5_SC);
  assign w_sc_ok  = r_resv_v && (addr[XLEN-1:3] == r_resv_a);
  assign w_unused = ^op_ir[6:0];

  // an external clear takes priority over a reservation being set on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resv_v <= 1'b0;
      r_resv_a <= '0;
    end else if (resv_clr) begin
      r_resv_v <= 1'b0;
    end else if (r_state == S_LOAD && mem_ack && r_is_lr) begin
      r_resv_v <= 1'b1;
      r_resv_a <= r_addr[XLEN-1:3];
    end else if (r_state == S_IDLE && req && w_is_sc && !w_err) begin
      r_resv_v <= 1'b0;
    end else if (r_state == S_RESP && !r_is_lr && !r_err) begin
      r_resv_v <= 1'b0;
    end
  end
`else
  assign w_is_lr  = 1'b0;
  assign w_is_sc  = 1'b0;
  assign w_sc_ok  = 1'b0;
  assign w_unused = ^{op_ir[6:0], resv_clr};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_err)        w_next = S_RESP;
          else if (w_is_sc) w_next = w_sc_ok ? S_STORE : S_RESP;
          else              w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        mem_rd = 1'b1;
        if (mem_ack) w_next = r_is_lr ? S_RESP : S_CALC;
      end
      S_CALC:  w_next = S_STORE;
      S_STORE: begin
        mem_wr = 1'b1;
        if (mem_ack) w_next = S_RESP;
      end
      S_RESP: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_w    <= 1'b0;
      r_is_swap <= 1'b0;
      r_is_lr   <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_rs2     <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_old     <= '0;
      r_new     <= '0;
      r_rd      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_is_w    <= w_is_w;
            r_is_swap <= (w_f5 == F5_SWAP);
            r_is_lr   <= w_is_lr;
            r_err     <= w_err;
            r_addr    <= addr;
            r_rs2     <= rs2;
            r_alu_b   <= w_is_w ? sext32(rs2[31:0]) : rs2;
            r_alu_op  <= remap(w_f5);
            r_new     <= rs2;
            r_rd      <= (w_is_sc && !w_sc_ok) ? {{(XLEN-1){1'b0}}, 1'b1} : '0;
          end
        end
        S_LOAD: begin
          if (mem_ack) begin
            r_old <= w_ld;
            r_rd  <= w_ld;
          end
        end
        S_CALC: r_new <= r_is_swap ? r_rs2 : alu_out;
        default: ;
      endcase
    end
  end

  assign err       = done && r_err;
  assign rd_data   = r_rd;
  assign alu_a     = r_old;
  assign alu_b     = r_alu_b;
  assign alu_op_ir = r_alu_op;
  assign mem_size  = !r_is_w;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_is_w ? {{(XLEN-32){1'b0}}, r_new[31:0]} : r_new;

endmodule

// File: tb/tb_amo_ctrl.sv
// Bench for amo_ctrl: memory/ALU responders plus a funct5-level reference model.
module tb_amo_ctrl;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [14:0] op_ir;
  logic [63:0] addr, rs2;
  logic        busy, done, err;
  logic [63:0] rd_data, alu_a, alu_b;
  logic [14:0] alu_op_ir;
  logic [63:0] alu_out;
  logic        mem_rd, mem_wr, mem_size;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        resv_clr;

  amo_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_ir(op_ir), .addr(addr), .rs2(rs2),
    .busy(busy), .done(done), .err(err), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_ir(alu_op_ir), .alu_out(alu_out),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .resv_clr(resv_clr)
  );

  always #5 clk = ~clk;

  // ALU responder
  always_comb begin
    alu_out = 64'hDEAD_BEEF_DEAD_BEEF;
    if (alu_op_ir[6:0] == 7'b0110011 && alu_op_ir[14:10] == 5'b0) begin
      case (alu_op_ir[9:7])
        3'b000:  alu_out = alu_a + alu_b;
        3'b100:  alu_out = alu_a ^ alu_b;
        3'b110:  alu_out = alu_a | alu_b;
        3'b111:  alu_out = alu_a & alu_b;
        default: alu_out = 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
    end else if (alu_op_ir[6:0] == 7'b0101111 && alu_op_ir[9:7] == 3'b000) begin
      case (alu_op_ir[14:10])
        F5_MIN:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
        F5_MAX:  alu_out = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
        F5_MINU: alu_out = (alu_a < alu_b) ? alu_a : alu_b;
        F5_MAXU: alu_out = (alu_a > alu_b) ? alu_a : alu_b;
        default: alu_out = 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
    end
  end

  // memory responder: 16 doublewords indexed by addr[6:3], ack after ack_dly wait cycles
  logic [63:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [63:0] pl_data = 64'd0;
  int          ack_dly = 0;
  int          wait_cnt = 0;
  int          nwr = 0;
  logic [63:0] cur_word;

  assign cur_word  = mem[mem_addr[6:3]];
  assign mem_ack   = (mem_rd || mem_wr) && (wait_cnt == ack_dly);
  assign mem_rdata = mem_size ? cur_word :
                     (mem_addr[2] ? {32'hA5A5_A5A5, cur_word[63:32]} : {32'hA5A5_A5A5, cur_word[31:0]});

  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                                wait_cnt <= 0;
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_wr && mem_ack) begin
      nwr <= nwr + 1;
      if (mem_size)         mem[mem_addr[6:3]]        <= mem_wdata;
      else if (mem_addr[2]) mem[mem_addr[6:3]][63:32] <= mem_wdata[31:0];
      else                  mem[mem_addr[6:3]][31:0]  <= mem_wdata[31:0];
    end
  end

  // reference model state
  logic [63:0] model_mem [0:15];
  logic        m_resv_v = 1'b0;
  logic [60:0] m_resv_a = '0;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  logic [63:0] g_rd, g_wd;
  logic        g_err;
  logic [14:0] g_aluop;
  int          g_lat, g_rc, g_wc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  task automatic model(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input int d,
                       output logic e_err, output logic [63:0] e_rd, output logic e_wr,
                       output logic [63:0] e_wd, output logic e_rdacc, output int e_lat);
    logic        w, dw, known;
    logic [3:0]  idx;
    logic [63:0] word, old, opb, nv;
    logic [31:0] lane;
    w     = (f3 == 3'b010);
    dw    = (f3 == 3'b011);
    known = f5 inside {F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND, F5_MIN, F5_MAX, F5_MINU, F5_MAXU};
`ifdef AMO_LRSC_EN
    known = known || (f5 == F5_LR) || (f5 == F5_SC);
`endif
    e_err   = !(w || dw) || (dw && a[2:0] != 3'b0) || (w && a[1:0] != 2'b0) || !known;
    e_rd    = '0;
    e_wr    = 1'b0;
    e_wd    = '0;
    e_rdacc = 1'b0;
    e_lat   = 1;
    nv      = '0;
    idx     = a[6:3];
    word    = model_mem[idx];
    lane    = a[2] ? word[63:32] : word[31:0];
    old     = dw ? word : sx(lane);
    opb     = dw ? b : sx(b[31:0]);
    if (!e_err) begin
      if (f5 == F5_LR) begin
        e_rd = old; e_rdacc = 1'b1; e_lat = 2 + d;
        m_resv_v = 1'b1; m_resv_a = a[63:3];
      end else if (f5 == F5_SC) begin
        if (m_resv_v && m_resv_a == a[63:3]) begin
          nv = b; e_wr = 1'b1; e_rd = '0; e_lat = 2 + d;
        end else begin
          e_rd = 64'd1; e_lat = 1;
        end
        m_resv_v = 1'b0;
      end else begin
        case (f5)
          F5_ADD:  nv = old + opb;
          F5_XOR:  nv = old ^ opb;
          F5_OR:   nv = old | opb;
          F5_AND:  nv = old & opb;
          F5_MIN:  nv = ($signed(old) < $signed(opb)) ? old : opb;
          F5_MAX:  nv = ($signed(old) > $signed(opb)) ? old : opb;
          F5_MINU: nv = (old < opb) ? old : opb;
          F5_MAXU: nv = (old > opb) ? old : opb;
          default: nv = b;
        endcase
        e_rd = old; e_rdacc = 1'b1; e_wr = 1'b1; e_lat = 4 + 2 * d;
        m_resv_v = 1'b0;
      end
      if (e_wr) begin
        e_wd = dw ? nv : {32'b0, nv[31:0]};
        if (dw)        model_mem[idx]        = nv;
        else if (a[2]) model_mem[idx][63:32] = nv[31:0];
        else           model_mem[idx][31:0]  = nv[31:0];
      end
    end
  endtask

  task automatic pl(input logic [3:0] i, input logic [63:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = i; pl_data = v; model_mem[i] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input int d, input bit pulse);
    logic        e_err, e_wr, e_rdacc;
    logic [63:0] e_rd, e_wd;
    int          e_lat, lat, rc, wc;
    logic [3:0]  idx;
    model(f5, f3, a, b, d, e_err, e_rd, e_wr, e_wd, e_rdacc, e_lat);
    @(negedge clk);
    ack_dly = d; op_ir = {f5, f3, 7'b0101111}; addr = a; rs2 = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0; lat = 1; rc = 0; wc = 0; g_wd = '0;
    while (!done && lat < 60) begin
      if (mem_rd) rc++;
      if (mem_wr) wc++;
      if (mem_wr && mem_ack) g_wd = mem_wdata;
      if (pulse && lat == 2) begin
        req = 1'b1; op_ir = {F5_ADD, 3'b011, 7'b0101111};
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    req = 1'b0;
    g_rd = rd_data; g_err = err; g_aluop = alu_op_ir; g_lat = lat; g_rc = rc; g_wc = wc;
    idx = a[6:3];
    chk("done_seen", 64'(done), 64'd1);
    chk("err", 64'(err), 64'(e_err));
    if (!e_err) chk("rd_data", rd_data, e_rd);
    chk("latency", 64'(lat), 64'(e_lat));
    chk("rd_cycles", 64'(rc), e_rdacc ? 64'(d + 1) : 64'd0);
    chk("wr_cycles", 64'(wc), e_wr ? 64'(d + 1) : 64'd0);
    if (e_wr) chk("wdata", g_wd, e_wd);
    chk("mem_word", mem[idx], model_mem[idx]);
  endtask

  logic [4:0] f5tab [12] = '{F5_ADD, F5_XOR, F5_OR, F5_AND, F5_MIN, F5_MAX,
                             F5_MINU, F5_MAXU, F5_SWAP, F5_LR, F5_SC, 5'b00101};

  initial begin
    int w0, lat;
    rst_n = 1'b0; req = 1'b0; op_ir = '0; addr = '0; rs2 = '0; resv_clr = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", 64'(alu_op_ir), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) pl(4'(i), {$urandom, $urandom});

    // amoadd.d, immediate ack
    pl(4'd0, 64'd5);
    run_op(F5_ADD, 3'b011, 64'h1000, 64'd3, 0, 1'b0);
    chk("t1_wdata", g_wd, 64'd8);
    chk("t1_rd", g_rd, 64'd5);
    chk("t1_lat", 64'(g_lat), 64'd4);
    chk("t1_err", 64'(g_err), 64'd0);

    // amomin.w on a negative word
    pl(4'd1, 64'h12345678_FFFFFFFE);
    run_op(F5_MIN, 3'b010, 64'h1008, 64'd1, 0, 1'b0);
    chk("t2_aluop", 64'(g_aluop), 64'({5'b10000, 3'b000, 7'b0101111}));
    chk("t2_wdata", g_wd, 64'h00000000_FFFFFFFE);
    chk("t2_rd", g_rd, 64'hFFFFFFFF_FFFFFFFE);

    // misaligned amoswap.d
    run_op(F5_SWAP, 3'b011, 64'h1004, 64'h77, 0, 1'b0);
    chk("t3_err", 64'(g_err), 64'd1);
    chk("t3_no_access", 64'(g_rc + g_wc), 64'd0);

    // amoxor.d with slow acks and a req pulse while busy
    pl(4'd3, 64'hF0F0_0000_1234_5678);
    w0 = nwr;
    run_op(F5_XOR, 3'b011, 64'h1018, 64'h0FF0_1111_0000_FFFF, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_idle_after", 64'(busy), 64'd0);
    chk("t4_one_write", 64'(nwr - w0), 64'd1);

    // reset while a store is outstanding
    pl(4'd2, 64'h00FF);
    @(negedge clk);
    ack_dly = 6; op_ir = {F5_AND, 3'b011, 7'b0101111}; addr = 64'h1010; rs2 = 64'h0F0; req = 1'b1;
    @(negedge clk);
    req = 1'b0; lat = 0;
    while (!mem_wr && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_in_store", 64'(mem_wr), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_wr_drop", 64'(mem_wr), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rd_drop", 64'(mem_rd), 64'd0);
    chk("t5_addr_clr", mem_addr, 64'd0);
    m_resv_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_mem_kept", mem[2], 64'h00FF);
    run_op(F5_ADD, 3'b011, 64'h1010, 64'd1, 0, 1'b0);
    chk("t5_after_rd", g_rd, 64'h00FF);

`ifdef AMO_LRSC_EN
    pl(4'd0, 64'hAAAA_5555_0000_0001);
    run_op(F5_LR, 3'b011, 64'h2000, 64'd0, 0, 1'b0);
    chk("t6_lr_rd", g_rd, 64'hAAAA_5555_0000_0001);
    run_op(F5_SC, 3'b011, 64'h2000, 64'h1234, 0, 1'b0);
    chk("t6_sc_rd", g_rd, 64'd0);
    chk("t6_sc_wr", 64'(g_wc), 64'd1);
    chk("t6_sc_mem", mem[0], 64'h1234);
    run_op(F5_LR, 3'b011, 64'h2000, 64'd0, 1, 1'b0);
    @(negedge clk);
    resv_clr = 1'b1; m_resv_v = 1'b0;
    @(negedge clk);
    resv_clr = 1'b0;
    run_op(F5_SC, 3'b011, 64'h2000, 64'h5555, 0, 1'b0);
    chk("t6_clr_rd", g_rd, 64'd1);
    chk("t6_clr_nowr", 64'(g_wc), 64'd0);
`else
    run_op(F5_LR, 3'b011, 64'h2000, 64'd0, 0, 1'b0);
    chk("t6_lr_unsupported", 64'(g_err), 64'd1);
    run_op(F5_SC, 3'b011, 64'h2000, 64'd9, 0, 1'b0);
    chk("t6_sc_unsupported", 64'(g_err), 64'd1);
`endif

    // randomized mix against the reference model
    for (int k = 0; k < 30; k++) begin
      logic [4:0]  f5;
      logic [2:0]  f3;
      logic [63:0] a, b;
      int          d;
      f5 = f5tab[$urandom_range(0, 11)];
      f3 = ($urandom_range(0, 9) == 0) ? 3'b001 : (($urandom_range(0, 1) == 1) ? 3'b011 : 3'b010);
      a  = 64'h1000 + {57'b0, 4'($urandom_range(0, 15)), 3'b000};
      if (f3 == 3'b010 && $urandom_range(0, 1) == 1) a[2] = 1'b1;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      b  = {$urandom, $urandom};
      d  = int'($urandom_range(0, 2));
      run_op(f5, f3, a, b, d, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/amo_ctrl.md
Name: amo_ctrl

Overview:
Sequencer for RV64A atomic memory operations in the hart.
- Runs the read-modify-write through the shared ALU and the data-memory port.
- Remaps AMO funct5 to ALU op_ir encodings. ALU op_amo handles min/max only; add/xor/and/or are re-encoded as rtype ops; swap bypasses the ALU.
- Returns the old memory value to rd.

Parameters:
XLEN, 64, data and address width; fixed at 64 for RV64.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
req  in  1  start AMO; sampled only in IDLE
op_ir  in  15  {funct5[14:10], funct3[9:7], opcode[6:0]}; funct3 010=W, 011=D
addr  in  64  effective address (rs1)
rs2  in  64  source operand
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle completion pulse
err  out  1  with done: misaligned, unsupported funct5 or bad funct3
rd_data  out  64  result for rd, valid while done=1
alu_a  out  64  ALU operand a (loaded value, sign-extended for W)
alu_b  out  64  ALU operand b (rs2, sign-extended for W)
alu_op_ir  out  15  remapped ALU op_ir
alu_out  in  64  ALU result
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_size  out  1  0=word, 1=doubleword
mem_addr  out  64  latched addr
mem_wdata  out  64  store data; W: {32'b0, value[31:0]}
mem_rdata  in  64  read data; W: word in [31:0]
mem_ack  in  1  completes current request; may assert in the first request cycle
resv_clr  in  1  clear LR reservation (trap/snoop); ignored without AMO_LRSC_EN

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, mem_rd, mem_wr = 0; rd_data, mem_addr, mem_wdata, alu_a, alu_b, alu_op_ir = 0. Reset mid-operation aborts immediately; mem_rd/mem_wr drop with rst_n.
- All control outputs decode from the state register (Moore); no combinational req→mem path.
- IDLE: on req, latch op_ir, addr, rs2.
  - Misaligned (D: addr[2:0]!=0; W: addr[1:0]!=0), funct3 not 010/011, or unsupported funct5 → RESP with err=1, no memory access.
  - Otherwise → LOAD.
- LOAD: mem_rd=1 until mem_ack. On ack, capture old = W ? sext(mem_rdata[31:0]) : mem_rdata, then → CALC.
- CALC (exactly 1 cycle): alu_a=old, alu_b=W ? sext(rs2[31:0]) : rs2. Capture new = alu_out, or rs2 for swap. → STORE.
- Remap to alu_op_ir:
  - amoadd 00000 → {5'b0, 3'b000, 7'b0110011}
  - amoxor 00100 → funct3 100
  - amoor 01000 → funct3 110
  - amoand 01100 → funct3 111
  - amomin/max/minu/maxu 10000/10100/11000/11100 → {funct5, 3'b0, 7'b0101111}
  - amoswap 00001 → ALU unused.
- W min/max: both operands sign-extended; unsigned ordering is preserved.
- STORE: mem_wr=1, mem_wdata=new (W: upper 32 bits zero) until mem_ack. → RESP.
- RESP (1 cycle): done=1, rd_data=old (or per LR/SC rules), err per decode. → IDLE.
- Minimum latency with same-cycle ack: req at T, done at T+4.
- req while busy: ignored, not queued. req in the cycle after RESP: accepted normally.

Optional Feature:
AMO_LRSC_EN.
- Defined: adds a reservation register (valid + doubleword-aligned address).
  - lr (00010): LOAD then RESP; rd=old; sets reservation.
  - sc (00011) with valid reservation and matching addr[63:3]: STORE rs2, rd=0.
  - sc otherwise: no memory access, rd=1.
  - Reservation is cleared by any sc, any completed AMO, and resv_clr.
  - resv_clr in the same cycle as an lr ack: clear wins.
- Not defined: funct5 00010/00011 decode as unsupported → err=1, no access; resv_clr ignored.

Test Plan:
1. amoadd.d, addr=0x1000, mem=5, rs2=3, 1-cycle ack → mem_wdata=8, rd_data=5, done at T+4, err=0.
2. amomin.w, mem word=0xFFFFFFFE, rs2=1 → alu_op_ir={10000,000,0101111}, mem_wdata=0x00000000FFFFFFFE, rd_data=0xFFFFFFFFFFFFFFFE.
3. amoswap.d addr=0x1004 → err=1 with done, mem_rd and mem_wr never asserted.
4. amoxor.d with mem_ack delayed 3 cycles on both read and write → mem_rd/mem_wr held steady; second req pulsed during busy is ignored.
5. rst_n low during STORE → mem_wr drops asynchronously, busy=0; next req completes normally.
6. AMO_LRSC_EN: lr.d 0x2000 then sc.d 0x2000 → rd=0, store occurs. Repeat with resv_clr between → rd=1, no mem_wr.
